ifctrl_mc: RTL

Multi-channel interface controller; successor to the single-port interface controller.
- Accepts acquire/release-framed request sessions from NUM_CH fan-in channels.
- Arbitrates channels round-robin.
- Buffers up to NUM_ROUTE routing words per session and forwards them to the Rename Unit.
- Forwards BRAM configuration words to the BRAM, then holds a run state until done.
- Sits between the fan-in trees and the Rename Unit / global-buffer BRAM.

---
 rtl/ifctrl_mc.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ifctrl_mc.sv
// ifctrl_mc: multi-channel interface controller; round-robin session grant, routing-word buffer, BRAM config forward.
// Optional watchdog via IFCTRL_MC_TIMEOUT_EN (adds TIMEOUT parameter and O_Tmo pulse).
package ifctrl_mc_pkg;
   typedef struct packed {
      logic        v;
      logic        acq;
      logic        rls;
      logic [31:0] d;
   } FTk_t;
   // d[31:30] classifies a word: 00 payload, 01 routing attr, 10 rconfig attr, 11 other attr
   localparam logic [1:0] ATTR_NONE  = 2'b00;
   localparam logic [1:0] ATTR_ROUTE = 2'b01;
   localparam logic [1:0] ATTR_RCFG  = 2'b10;
endpackage

module ifctrl_mc
   import ifctrl_mc_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int NUM_ROUTE = 4
`ifdef IFCTRL_MC_TIMEOUT_EN
   , parameter int TIMEOUT = 1024
`endif
) (
   input  logic                           clock,
   input  logic                           reset,
   input  FTk_t                           I_FTk [NUM_CH],
   output logic [NUM_CH-1:0]              O_Nack,
   output FTk_t                           O_FTk,
   output FTk_t                           O_RCFG,
   output logic                           O_Req,
   output logic [NUM_CH-1:0]              O_Grant,
   output logic [$clog2(NUM_CH)-1:0]      O_ChID,
   output logic [$clog2(NUM_ROUTE+1)-1:0] O_RNum,
   output logic                           O_Ovf,
   output logic                           O_Busy,
   input  logic                           I_Stall,
   input  logic                           I_Done,
   input  logic                           I_St_Done,
   input  logic                           I_Rls
`ifdef IFCTRL_MC_TIMEOUT_EN
   , output logic                         O_Tmo
`endif
);
   localparam int WIDTH_CH = $clog2(NUM_CH);
   localparam int CW       = $clog2(NUM_ROUTE+1);
   localparam int DEPTH    = 1 << CW;

   typedef enum logic [2:0] {IDLE, ID_T, ID_F, ATTRIB, ROUTE, RATRIB, RCFG, RUN} state_t;
   state_t state;

   FTk_t                sel;
   logic [NUM_CH-1:0]   acq;
   logic [NUM_CH-1:0]   win_oh;
   logic [WIDTH_CH-1:0] rr;
   logic [WIDTH_CH-1:0] win_idx;
   logic                win_vld;
   logic [31:0]         rbuf [DEPTH];
   logic [CW-1:0]       rd;
   logic                draining;
   logic                accept;
   logic                wr_en;
   logic                end_session;
   logic                tmo_fire;

   assign sel    = I_FTk[O_ChID];
   assign accept = sel.v & ~I_Stall;
   assign wr_en  = (state == ROUTE) & ~draining & accept & (sel.d[31:30] == ATTR_NONE);
   assign O_Busy = (state != IDLE);

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) acq[k] = I_FTk[k].acq;
   end

   // first requester at or after the round-robin pointer
   always_comb begin
      logic [WIDTH_CH:0] j;
      j       = '0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         j = {1'b0, rr} + (WIDTH_CH+1)'(k);
         if (j >= (WIDTH_CH+1)'(NUM_CH)) j = j - (WIDTH_CH+1)'(NUM_CH);
         if (!win_vld && acq[j[WIDTH_CH-1:0]]) begin
            win_vld = 1'b1;
            win_idx = j[WIDTH_CH-1:0];
         end
      end
      win_oh = '0;
      if (win_vld) win_oh[win_idx] = 1'b1;
   end

   assign end_session = (sel.rls && (state inside {ID_T, ID_F, ATTRIB, RATRIB}))
                      | ((state == RUN) && I_Done) | tmo_fire;

   always_ff @(posedge clock) begin
      if (wr_en && (O_RNum < CW'(NUM_ROUTE))) rbuf[O_RNum] <= sel.d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr       <= '0;
         O_Grant  <= '0;
         O_ChID   <= '0;
         O_Nack   <= '0;
         O_FTk    <= '0;
         O_RCFG   <= '0;
         O_Req    <= 1'b0;
         O_RNum   <= '0;
         O_Ovf    <= 1'b0;
         rd       <= '0;
         draining <= 1'b0;
      end else begin
         O_Req  <= 1'b0;
         O_RCFG <= '0;
         O_Nack <= (state == IDLE) ? (acq & ~win_oh) : (acq & ~O_Grant);

         // a drain beat outranks the external clears
         if (!I_Stall) begin
            if (draining && (rd != O_RNum)) begin
               O_FTk <= '{v: 1'b1, acq: 1'b0, rls: 1'b0, d: rbuf[rd]};
               rd    <= rd + 1'b1;
            end else if (I_Rls || I_St_Done) begin
               O_FTk <= '0;
            end else begin
               O_FTk.v <= 1'b0;
            end
         end

         case (state)
            IDLE: if (win_vld) begin
               O_Grant <= win_oh;
               O_ChID  <= win_idx;
               rr      <= (win_idx == WIDTH_CH'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
               state   <= ID_T;
            end
            ID_T: if (sel.v) state <= ID_F;
            ID_F: if (sel.v) state <= ATTRIB;
            ATTRIB: if (accept) begin
               if (sel.d[31:30] == ATTR_ROUTE)     state <= ROUTE;
               else if (sel.d[31:30] == ATTR_RCFG) state <= RCFG;
            end
            ROUTE: begin
               if (draining) begin
                  if (rd == O_RNum) begin
                     draining <= 1'b0;
                     state    <= RUN;
                  end
               end else begin
                  if (wr_en) begin
                     if (O_RNum < CW'(NUM_ROUTE)) O_RNum <= O_RNum + 1'b1;
                     else                         O_Ovf  <= 1'b1;
                  end
                  if (sel.rls) begin
                     O_Req    <= 1'b1;
                     draining <= 1'b1;
                     rd       <= '0;
                  end else if (accept && (sel.d[31:30] != ATTR_NONE)
                               && (sel.d[31:30] != ATTR_ROUTE)) begin
                     state <= RATRIB;
                  end
               end
            end
            RATRIB: if (accept) state <= RCFG;
            RCFG: begin
               if (accept) O_RCFG <= sel;
               if (sel.rls) begin
                  O_Req    <= 1'b1;
                  draining <= 1'b1;
                  rd       <= '0;
                  state    <= RUN;
               end
            end
            RUN: if (draining && (rd == O_RNum)) draining <= 1'b0;
            default: state <= IDLE;
         endcase

         if (end_session) begin
            state    <= IDLE;
            O_Grant  <= '0;
            O_ChID   <= '0;
            O_RNum   <= '0;
            O_Ovf    <= 1'b0;
            draining <= 1'b0;
            rd       <= '0;
         end
      end
   end

`ifdef IFCTRL_MC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   state_t        prev_state;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_eff;
   logic          in_win;

   // a state change restarts the count in the same cycle it is observed
   assign in_win   = state inside {ID_T, ID_F, ATTRIB, ROUTE, RATRIB, RCFG};
   assign tmo_eff  = (state != prev_state) ? '0 : tmo_q;
   assign tmo_fire = in_win & ~sel.v & (tmo_eff == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_state <= IDLE;
         tmo_q      <= '0;
         O_Tmo      <= 1'b0;
      end else begin
         prev_state <= state;
         tmo_q      <= (!in_win || sel.v) ? '0 : tmo_eff + 1'b1;
         O_Tmo      <= tmo_fire;
      end
   end
`else
   assign tmo_fire = 1'b0;
`endif
endmodule
